rv64_decode_stage: RTL and testbench

//  Registered RV64IM-subset instruction decoder; the decode side of the encoders used by the core bench.

---
 rtl/rv64_decode_stage.sv | 261 ++++++++++++++++++++++++++
 tb/tb_rv64_decode_stage.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv64_decode_stage.sv
// rv64_decode_stage
//   Registered decoder for the RV64IM subset used by the core (ADDI, ADD, SUB,
//   AND, OR, MUL, LD, SD, BEQ, BNE). A fetched 32-bit word is cracked into
//   register indices, a sign-extended immediate and control strobes, then held
//   in a one-entry output register with a valid/ready handshake.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active low
//   in_valid     fetch presents in_inst / in_pc
//   in_ready     stage can accept (output register empty or being drained)
//   in_inst      raw instruction word
//   in_pc        byte PC of in_inst
//   flush        kill the held bundle and the incoming word (taken branch)
//   out_valid    decoded bundle valid
//   out_ready    execute consumes the bundle
//   out_pc       PC of the held instruction
//   rs1/rs2/rd   register indices, always raw-extracted
//   imm          sign-extended immediate (I/S/B form by opcode, 0 otherwise)
//   alu_op       0 ADD, 1 SUB, 2 AND, 3 OR, 4 MUL, 7 none
//   alu_src_imm  operand B comes from imm
//   reg_write    writes rd (never for rd == x0)
//   mem_read     LD
//   mem_write    SD
//   branch       BEQ/BNE
//   branch_ne    1 = BNE, 0 = BEQ
//   illegal      unsupported encoding
//   decoded_cnt  bundles handed off
//   illegal_cnt  handed-off bundles flagged illegal
module rv64_decode_stage #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic [XLEN-1:0]  imm,
  output logic [2:0]       alu_op,
  output logic             alu_src_imm,
  output logic             reg_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             branch,
  output logic             branch_ne,
  output logic             illegal,
  output logic [CNT_W-1:0] decoded_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_MUL  = 3'd4,
    ALU_NONE = 3'd7
  } alu_e;

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  function automatic logic signed [XLEN-1:0] sext12(input logic [11:0] v);
    return XLEN'($signed(v));
  endfunction

  function automatic logic signed [XLEN-1:0] sext13(input logic [12:0] v);
    return XLEN'($signed(v));
  endfunction

  // Combinational decode of the incoming word
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];

  logic signed [XLEN-1:0] dec_imm;
  alu_e                   dec_alu;
  logic                   dec_src_imm;
  logic                   dec_rw;
  logic                   dec_mr;
  logic                   dec_mw;
  logic                   dec_br;
  logic                   dec_bne;
  logic                   dec_ill;

  always_comb begin
    dec_imm     = '0;
    dec_alu     = ALU_NONE;
    dec_src_imm = 1'b0;
    dec_rw      = 1'b0;
    dec_mr      = 1'b0;
    dec_mw      = 1'b0;
    dec_br      = 1'b0;
    dec_bne     = 1'b0;
    dec_ill     = 1'b1;
    // Full 7-bit opcode compare also rejects compressed words (inst[1:0] != 2'b11).
    case (opcode)
      OPC_OPIMM: begin
        if (funct3 == 3'b000) begin
          dec_ill     = 1'b0;
          dec_alu     = ALU_ADD;
          dec_src_imm = 1'b1;
          dec_rw      = 1'b1;
          dec_imm     = sext12(in_inst[31:20]);
        end
      end
      OPC_OP: begin
        dec_ill = 1'b0;
        dec_rw  = 1'b1;
        if (funct3 == 3'b000 && funct7 == 7'b0000000)      dec_alu = ALU_ADD;
        else if (funct3 == 3'b000 && funct7 == 7'b0100000) dec_alu = ALU_SUB;
        else if (funct3 == 3'b000 && funct7 == 7'b0000001) dec_alu = ALU_MUL;
        else if (funct3 == 3'b111 && funct7 == 7'b0000000) dec_alu = ALU_AND;
        else if (funct3 == 3'b110 && funct7 == 7'b0000000) dec_alu = ALU_OR;
        else begin
          dec_ill = 1'b1;
          dec_rw  = 1'b0;
        end
      end
      OPC_LOAD: begin
        if (funct3 == 3'b011) begin
          dec_ill     = 1'b0;
          dec_alu     = ALU_ADD;
          dec_src_imm = 1'b1;
          dec_mr      = 1'b1;
          dec_rw      = 1'b1;
          dec_imm     = sext12(in_inst[31:20]);
        end
      end
      OPC_STORE: begin
        if (funct3 == 3'b011) begin
          dec_ill     = 1'b0;
          dec_alu     = ALU_ADD;
          dec_src_imm = 1'b1;
          dec_mw      = 1'b1;
          dec_imm     = sext12({in_inst[31:25], in_inst[11:7]});
        end
      end
      OPC_BRANCH: begin
        if (funct3 == 3'b000 || funct3 == 3'b001) begin
          dec_ill = 1'b0;
          dec_alu = ALU_SUB;
          dec_br  = 1'b1;
          dec_bne = funct3[0];
          dec_imm = sext13({in_inst[31], in_inst[7], in_inst[30:25],
                            in_inst[11:8], 1'b0});
        end
      end
      default: ;
    endcase
    // x0 is hardwired, so writes to it (including the canonical NOP) are suppressed.
    if (in_inst[11:7] == 5'd0) dec_rw = 1'b0;
  end

  // Handshake and counter control
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] dec_cnt_q, dec_cnt_d;
  logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;
  logic             ill_q;
  logic             accept;
  logic             handoff;

  assign in_ready = !valid_q || out_ready;
  // Flush overrides both sides: nothing is loaded and nothing counts as handed off.
  assign accept   = in_valid && in_ready && !flush;
  assign handoff  = valid_q && out_ready && !flush;

  always_comb begin
    valid_d   = valid_q;
    dec_cnt_d = dec_cnt_q;
    ill_cnt_d = ill_cnt_q;
    if (flush)        valid_d = 1'b0;
    else if (accept)  valid_d = 1'b1;
    else if (handoff) valid_d = 1'b0;
    if (handoff) begin
      dec_cnt_d = dec_cnt_q + CNT_W'(1);
      if (ill_q) ill_cnt_d = ill_cnt_q + CNT_W'(1);
    end
  end

  // Output register stage
  logic [XLEN-1:0]        pc_q;
  logic [4:0]             rs1_q, rs2_q, rd_q;
  logic signed [XLEN-1:0] imm_q;
  alu_e                   alu_q;
  logic                   src_imm_q, rw_q, mr_q, mw_q, br_q, bne_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      dec_cnt_q <= '0;
      ill_cnt_q <= '0;
      pc_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      alu_q     <= ALU_NONE;
      src_imm_q <= 1'b0;
      rw_q      <= 1'b0;
      mr_q      <= 1'b0;
      mw_q      <= 1'b0;
      br_q      <= 1'b0;
      bne_q     <= 1'b0;
      ill_q     <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      dec_cnt_q <= dec_cnt_d;
      ill_cnt_q <= ill_cnt_d;
      if (accept) begin
        pc_q      <= in_pc;
        rs1_q     <= in_inst[19:15];
        rs2_q     <= in_inst[24:20];
        rd_q      <= in_inst[11:7];
        imm_q     <= dec_imm;
        alu_q     <= dec_alu;
        src_imm_q <= dec_src_imm;
        rw_q      <= dec_rw;
        mr_q      <= dec_mr;
        mw_q      <= dec_mw;
        br_q      <= dec_br;
        bne_q     <= dec_bne;
        ill_q     <= dec_ill;
      end
    end
  end

  assign out_valid   = valid_q;
  assign out_pc      = pc_q;
  assign rs1         = rs1_q;
  assign rs2         = rs2_q;
  assign rd          = rd_q;
  assign imm         = imm_q;
  assign alu_op      = alu_q;
  assign alu_src_imm = src_imm_q;
  assign reg_write   = rw_q;
  assign mem_read    = mr_q;
  assign mem_write   = mw_q;
  assign branch      = br_q;
  assign branch_ne   = bne_q;
  assign illegal     = ill_q;
  assign decoded_cnt = dec_cnt_q;
  assign illegal_cnt = ill_cnt_q;

endmodule

// File: tb/tb_rv64_decode_stage.sv
// tb_rv64_decode_stage
//   Scoreboard bench for rv64_decode_stage. A reference decoder classifies
//   each word by mnemonic and builds the immediate with signed arithmetic.
//   Accepted words are queued; a negedge monitor compares the held bundle,
//   handshake signals and counters against the queue and the bench's own
//   handshake bookkeeping.
module tb_rv64_decode_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [4:0]  rs1, rs2, rd;
  logic [63:0] imm;
  logic [2:0]  alu_op;
  logic        alu_src_imm, reg_write, mem_read, mem_write;
  logic        branch, branch_ne, illegal;
  logic [31:0] decoded_cnt, illegal_cnt;

  rv64_decode_stage #(.XLEN(64), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .alu_op(alu_op),
    .alu_src_imm(alu_src_imm), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .branch(branch), .branch_ne(branch_ne),
    .illegal(illegal), .decoded_cnt(decoded_cnt), .illegal_cnt(illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [63:0] imm;
    logic [2:0]  alu;
    logic        src, rw, mr, mw, br, bne, ill;
  } exp_t;

  typedef enum {K_ILL, K_ADDI, K_ADD, K_SUB, K_AND, K_OR, K_MUL, K_LD, K_SD,
                K_BEQ, K_BNE} kind_e;

  exp_t sb[$];
  bit   m_valid = 1'b0;
  int   total = 0;
  int   bad = 0;
  int unsigned exp_dec = 0;
  int unsigned exp_ill = 0;

  function automatic exp_t ref_decode(input logic [31:0] w, input logic [63:0] pc);
    exp_t   e;
    kind_e  k;
    longint s, ii, is, ib;
    int     op, f3, f7;
    op = int'(w & 32'h7f);
    f3 = int'((w >> 12) & 32'h7);
    f7 = int'(w >> 25);
    k  = K_ILL;
    if (op == 'h13 && f3 == 0) k = K_ADDI;
    if (op == 'h33) begin
      if (f3 == 0 && f7 == 'h00) k = K_ADD;
      if (f3 == 0 && f7 == 'h20) k = K_SUB;
      if (f3 == 0 && f7 == 'h01) k = K_MUL;
      if (f3 == 7 && f7 == 'h00) k = K_AND;
      if (f3 == 6 && f7 == 'h00) k = K_OR;
    end
    if (op == 'h03 && f3 == 3) k = K_LD;
    if (op == 'h23 && f3 == 3) k = K_SD;
    if (op == 'h63 && f3 == 0) k = K_BEQ;
    if (op == 'h63 && f3 == 1) k = K_BNE;

    s  = longint'($signed(w));
    ii = s >>> 20;
    is = ((s >>> 25) * 32) + longint'((w >> 7) & 32'h1f);
    ib = ((s >>> 31) * 4096) + longint'((w >> 7) & 32'h1) * 2048
         + longint'((w >> 25) & 32'h3f) * 32 + longint'((w >> 8) & 32'hf) * 2;

    e.pc  = pc;
    e.rs1 = 5'((w >> 15) & 32'h1f);
    e.rs2 = 5'((w >> 20) & 32'h1f);
    e.rd  = 5'((w >> 7) & 32'h1f);
    e.imm = 64'd0;
    e.alu = 3'd7;
    e.src = 0; e.rw = 0; e.mr = 0; e.mw = 0; e.br = 0; e.bne = 0; e.ill = 0;
    case (k)
      K_ADDI: begin e.alu = 0; e.src = 1; e.rw = 1; e.imm = ii; end
      K_ADD:  begin e.alu = 0; e.rw = 1; end
      K_SUB:  begin e.alu = 1; e.rw = 1; end
      K_AND:  begin e.alu = 2; e.rw = 1; end
      K_OR:   begin e.alu = 3; e.rw = 1; end
      K_MUL:  begin e.alu = 4; e.rw = 1; end
      K_LD:   begin e.alu = 0; e.src = 1; e.mr = 1; e.rw = 1; e.imm = ii; end
      K_SD:   begin e.alu = 0; e.src = 1; e.mw = 1; e.imm = is; end
      K_BEQ:  begin e.alu = 1; e.br = 1; e.imm = ib; end
      K_BNE:  begin e.alu = 1; e.br = 1; e.bne = 1; e.imm = ib; end
      default: e.ill = 1;
    endcase
    if (e.rd == 0) e.rw = 0;
    return e;
  endfunction

  function automatic logic [31:0] gen_legal();
    logic [4:0]  a, b, d;
    logic [11:0] i;
    int          k;
    a = 5'($urandom); b = 5'($urandom);
    d = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
    i = 12'($urandom);
    k = $urandom_range(0, 9);
    case (k)
      0: return {i, a, 3'b000, d, 7'h13};
      1: return {7'h00, b, a, 3'b000, d, 7'h33};
      2: return {7'h20, b, a, 3'b000, d, 7'h33};
      3: return {7'h00, b, a, 3'b111, d, 7'h33};
      4: return {7'h00, b, a, 3'b110, d, 7'h33};
      5: return {7'h01, b, a, 3'b000, d, 7'h33};
      6: return {i, a, 3'b011, d, 7'h03};
      7: return {i[11:5], b, a, 3'b011, i[4:0], 7'h23};
      8: return {i[11], i[9:4], b, a, 3'b000, i[3:0], i[10], 7'h63};
      default: return {i[11], i[9:4], b, a, 3'b001, i[3:0], i[10], 7'h63};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  // Handshake model: acceptance and flush bookkeeping at each rising edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid = 1'b0;
      sb.delete();
    end else if (flush) begin
      if (m_valid && sb.size() > 0) void'(sb.pop_back());
      m_valid = 1'b0;
    end else begin
      bit acc;
      acc = in_valid && (!m_valid || out_ready);
      if (m_valid && out_ready) m_valid = 1'b0;
      if (acc) begin
        sb.push_back(ref_decode(in_inst, in_pc));
        m_valid = 1'b1;
      end
    end
  end

  // Monitor: compares outputs between edges.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_alu_op", alu_op, 7);
      chk("rst_imm", imm, 0);
      chk("rst_reg_write", reg_write, 0);
      chk("rst_decoded_cnt", decoded_cnt, 0);
      chk("rst_illegal_cnt", illegal_cnt, 0);
      exp_dec = 0;
      exp_ill = 0;
    end else begin
      chk("out_valid", out_valid, m_valid);
      chk("in_ready", in_ready, !m_valid || out_ready);
      chk("decoded_cnt", decoded_cnt, exp_dec);
      chk("illegal_cnt", illegal_cnt, exp_ill);
      if (out_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_bundle actual pc=%h required none", out_pc);
        end else begin
          e = sb[0];
          chk("out_pc", out_pc, e.pc);
          chk("rs1", rs1, e.rs1);
          chk("rs2", rs2, e.rs2);
          chk("rd", rd, e.rd);
          chk("imm", imm, e.imm);
          chk("alu_op", alu_op, e.alu);
          chk("alu_src_imm", alu_src_imm, e.src);
          chk("reg_write", reg_write, e.rw);
          chk("mem_read", mem_read, e.mr);
          chk("mem_write", mem_write, e.mw);
          chk("branch", branch, e.br);
          chk("branch_ne", branch_ne, e.bne);
          chk("illegal", illegal, e.ill);
          if (out_ready && !flush) begin
            void'(sb.pop_front());
            exp_dec++;
            if (e.ill) exp_ill++;
          end
        end
        // Hand-computed expectations for the named directed words.
        case (out_pc)
          64'h1000: begin
            chk("T1_rd", rd, 1); chk("T1_rs1", rs1, 0); chk("T1_imm", imm, 5);
            chk("T1_alu", alu_op, 0); chk("T1_rw", reg_write, 1);
          end
          64'h2000: chk("T2_mul_alu", alu_op, 4);
          64'h2004: begin
            chk("T2_sd_mw", mem_write, 1); chk("T2_sd_rs2", rs2, 3);
            chk("T2_sd_imm", imm, 0); chk("T2_sd_rw", reg_write, 0);
          end
          64'h3000: begin
            chk("T3_beq_br", branch, 1); chk("T3_beq_ne", branch_ne, 0);
            chk("T3_beq_imm", imm, 8);
          end
          64'h3004: begin
            chk("T3_bne_ne", branch_ne, 1);
            chk("T3_bne_imm", imm, 64'hFFFF_FFFF_FFFF_FFFC);
          end
          64'h5000: begin
            chk("T5_illegal", illegal, 1); chk("T5_rw", reg_write, 0);
            chk("T5_mw", mem_write, 0); chk("T5_br", branch, 0);
            chk("T5_alu", alu_op, 7);
          end
          64'h5010: chk("T5_nop_rw", reg_write, 0);
          default: ;
        endcase
      end
    end
  end

  // Inputs are applied just after a rising edge and held for the next one.
  task automatic cyc(input logic v, input logic [31:0] w, input logic [63:0] pc,
                     input logic ordy, input logic fl);
    in_valid  = v;
    in_inst   = w;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle(1);

    // T1: ADDI x1,x0,5
    cyc(1, 32'h00500093, 64'h1000, 1, 0);
    idle(2);
    // T2: MUL then SD back-to-back
    cyc(1, 32'h022083B3, 64'h2000, 1, 0);
    cyc(1, 32'h00303023, 64'h2004, 1, 0);
    idle(2);
    // T3: BEQ +8, BNE -4
    cyc(1, 32'h00818463, 64'h3000, 1, 0);
    cyc(1, 32'hFE419EE3, 64'h3004, 1, 0);
    idle(2);
    // T4: stall for 5 cycles with a word waiting, then release
    cyc(1, 32'h00100093, 64'h4000, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, 32'h00A00113, 64'h4004, 0, 0);
    cyc(1, 32'h00A00113, 64'h4004, 1, 0);
    idle(2);
    // T5: illegal word, then flush of a stalled bundle plus incoming word
    cyc(1, 32'hFFFFFFFF, 64'h5000, 0, 0);
    cyc(0, 32'h0, 64'h0, 0, 0);
    cyc(0, 32'h0, 64'h0, 1, 0);
    cyc(1, 32'h00100093, 64'h5008, 0, 0);
    cyc(0, 32'h0, 64'h0, 0, 0);
    cyc(1, 32'h00200093, 64'h500C, 0, 1);
    cyc(0, 32'h0, 64'h0, 0, 0);
    cyc(1, 32'h00000013, 64'h5010, 1, 0);
    cyc(1, 32'h00000003, 64'h5014, 1, 0);
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] w;
      w = ($urandom_range(0, 3) == 0) ? $urandom : gen_legal();
      cyc(($urandom_range(0, 3) != 0), w, {32'h0000_0100, $urandom & 32'hFFFF_FFFC},
          ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0));
    end
    idle(3);

    // T6: reset asserted while a bundle is held
    cyc(1, 32'h00500093, 64'h6000, 0, 0);
    cyc(0, 32'h0, 64'h0, 0, 0);
    rst = 1'b0;
    cyc(0, 32'h0, 64'h0, 1, 0);
    rst = 1'b1;
    idle(2);
    cyc(1, 32'h022083B3, 64'h6004, 1, 0);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
